// File: rtl/ad_adc_capture_seq_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package ad_adc_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_DELAY   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } cap_state_t;

   // Mode 3 is not listed and behaves like MODE_IMM.
   localparam logic [1:0] MODE_IMM   = 2'd0;
   localparam logic [1:0] MODE_EDGE  = 2'd1;
   localparam logic [1:0] MODE_LEVEL = 2'd2;

endpackage

// File: rtl/ad_adc_capture_seq_if.sv
// Beat stream (valid + data) between channel, sequencer and DMA; no backpressure.
interface ad_adc_capture_seq_if #(
   parameter int DATA_WIDTH = 256
);
   logic                  valid;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data);
   modport slave  (input  valid, input  data);
endinterface

// File: rtl/ad_adc_capture_seq_trig_detect.sv
// Trigger qualifier: rising-edge or level detection of trig_in for the latched mode.
module ad_trig_detect
   import ad_adc_capture_pkg::*;
(
   input  logic       adc_clk,
   input  logic       adc_rst,
   input  logic [1:0] mode,
   input  logic       trig_in,
   output logic       fire
);

   logic trig_d;

   // previous-cycle trigger level; a trigger already high at arm time gives no edge
   always_ff @(posedge adc_clk) begin
      if (adc_rst) trig_d <= 1'b0;
      else         trig_d <= trig_in;
   end

   // immediate mode never fires here; the sequencer bypasses ARMED for it
   always_comb begin
      fire = 1'b0;
      if (mode == MODE_EDGE)       fire = trig_in & ~trig_d;
      else if (mode == MODE_LEVEL) fire = trig_in;
   end

endmodule

// File: rtl/ad_adc_capture_seq.sv
// Capture sequencer: arm, wait for trigger, skip delay beats, forward length beats to DMA.
module ad_adc_capture_seq
   import ad_adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH   = 256,
   parameter int LENGTH_WIDTH = 16,
   parameter int DELAY_WIDTH  = 16
) (
   input  logic                    adc_clk,
   input  logic                    adc_rst,
   input  logic                    cfg_start,
   input  logic                    cfg_abort,
   input  logic [1:0]              cfg_mode,
   input  logic [DELAY_WIDTH-1:0]  cfg_delay,
   input  logic [LENGTH_WIDTH-1:0] cfg_length,
   input  logic                    trig_in,
   ad_adc_capture_seq_if.slave     adc_in,
   input  logic                    adc_dovf,
   ad_adc_capture_seq_if.master    adc_out,
   output logic                    status_busy,
   output logic                    status_armed,
   output logic                    status_done,
   output logic                    status_ovf,
   output logic [LENGTH_WIDTH-1:0] status_count
);

   localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);
   localparam logic [DELAY_WIDTH-1:0]  DLY_ONE = DELAY_WIDTH'(1);

   cap_state_t              state, state_nxt;
   logic [1:0]              mode_q;
   logic [DELAY_WIDTH-1:0]  delay_q, dly_cnt, dly_inc;
   logic [LENGTH_WIDTH-1:0] length_q, cnt_inc;
   logic                    fire, start_ok, fwd;
   logic                    vld_p1;
   logic [DATA_WIDTH-1:0]   data_p1;

   assign dly_inc  = dly_cnt + DLY_ONE;
   assign cnt_inc  = status_count + LEN_ONE;
   assign start_ok = cfg_start & ~cfg_abort & ((state == ST_IDLE) | (state == ST_DONE));

   ad_trig_detect u_trig (
      .adc_clk (adc_clk),
      .adc_rst (adc_rst),
      .mode    (mode_q),
      .trig_in (trig_in),
      .fire    (fire)
   );

   // state register
   always_ff @(posedge adc_clk) begin
      if (adc_rst) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // next-state logic; abort overrides everything, including a same-cycle start
   always_comb begin
      state_nxt = state;
      if (cfg_abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (cfg_start) begin
                  if (cfg_length == '0)                               state_nxt = ST_DONE;
                  else if (cfg_mode == MODE_EDGE || cfg_mode == MODE_LEVEL) state_nxt = ST_ARMED;
                  else if (cfg_delay == '0)                           state_nxt = ST_CAPTURE;
                  else                                                state_nxt = ST_DELAY;
               end
            end
            ST_ARMED:   if (fire) state_nxt = (delay_q == '0) ? ST_CAPTURE : ST_DELAY;
            ST_DELAY:   if (adc_in.valid && dly_inc == delay_q) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if ((adc_in.valid && cnt_inc == length_q) || adc_dovf) state_nxt = ST_DONE;
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   // state-decoded outputs and the forward enable for the datapath
   always_comb begin
      status_busy  = (state == ST_ARMED) | (state == ST_DELAY) | (state == ST_CAPTURE);
      status_armed = (state == ST_ARMED);
      fwd          = (state == ST_CAPTURE) & adc_in.valid & ~cfg_abort;
   end

   // configuration latch, delay counter and sticky status, updated with the state
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         mode_q       <= MODE_IMM;
         delay_q      <= '0;
         length_q     <= '0;
         dly_cnt      <= '0;
         status_done  <= 1'b0;
         status_ovf   <= 1'b0;
         status_count <= '0;
      end else if (start_ok) begin
         mode_q       <= cfg_mode;
         delay_q      <= cfg_delay;
         length_q     <= cfg_length;
         dly_cnt      <= '0;
         status_done  <= (cfg_length == '0);
         status_ovf   <= 1'b0;
         status_count <= '0;
      end else if (!cfg_abort) begin
         if (state == ST_DELAY && adc_in.valid) dly_cnt <= dly_inc;
         if (state == ST_CAPTURE) begin
            if (adc_in.valid) status_count <= cnt_inc;
            if ((adc_in.valid && cnt_inc == length_q) || adc_dovf) status_done <= 1'b1;
            if (adc_dovf) status_ovf <= 1'b1;
         end
      end
   end

   // ---- stage p1: one-cycle registered beat towards the DMA ----
   // data only loads on a forwarded beat so it holds while valid is low
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= fwd;
         if (fwd) data_p1 <= adc_in.data;
      end
   end

   assign adc_out.valid = vld_p1;
   assign adc_out.data  = data_p1;

endmodule

// File: tb/tb_ad_adc_capture_seq.sv
// Bench for ad_adc_capture_seq: directed scenarios plus randomized runs against a beat-list model.
module tb_ad_adc_capture_seq;
   import ad_adc_capture_pkg::*;

   localparam int DW   = 256;
   localparam int LW   = 16;
   localparam int WW   = 16;
   localparam int MAXC = 64;

   logic          adc_clk = 1'b0;
   logic          adc_rst;
   logic          cfg_start, cfg_abort, trig_in, adc_dovf;
   logic [1:0]    cfg_mode;
   logic [WW-1:0] cfg_delay;
   logic [LW-1:0] cfg_length;
   logic          status_busy, status_armed, status_done, status_ovf;
   logic [LW-1:0] status_count;

   ad_adc_capture_seq_if #(.DATA_WIDTH(DW)) src ();
   ad_adc_capture_seq_if #(.DATA_WIDTH(DW)) dst ();

   ad_adc_capture_seq #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .DELAY_WIDTH(WW)) dut (
      .adc_clk      (adc_clk),
      .adc_rst      (adc_rst),
      .cfg_start    (cfg_start),
      .cfg_abort    (cfg_abort),
      .cfg_mode     (cfg_mode),
      .cfg_delay    (cfg_delay),
      .cfg_length   (cfg_length),
      .trig_in      (trig_in),
      .adc_in       (src.slave),
      .adc_dovf     (adc_dovf),
      .adc_out      (dst.master),
      .status_busy  (status_busy),
      .status_armed (status_armed),
      .status_done  (status_done),
      .status_ovf   (status_ovf),
      .status_count (status_count)
   );

   always #5 adc_clk = ~adc_clk;

   int checks;
   int errors;

   // per-cycle stimulus of one run; cycle 0 carries the start pulse
   logic          v [MAXC];
   logic          tr[MAXC];
   logic          ov[MAXC];
   logic          ab[MAXC];
   logic          st[MAXC];
   logic [DW-1:0] d [MAXC];
   logic          arm_obs[MAXC];

   // expected results
   int            exp_idx[$];
   logic [DW-1:0] exp_dat[$];
   logic          exp_done, exp_ovf, exp_busy;
   logic [LW-1:0] exp_cnt;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      cfg_start = 1'b0; cfg_abort = 1'b0; cfg_mode = MODE_IMM;
      cfg_delay = '0;   cfg_length = '0;  trig_in = 1'b0;
      adc_dovf = 1'b0;  src.valid = 1'b0; src.data = '0;
   endtask

   task automatic clear_stim();
      for (int k = 0; k < MAXC; k++) begin
         v[k] = 1'b0; tr[k] = 1'b0; ov[k] = 1'b0; ab[k] = 1'b0; st[k] = 1'b0;
         d[k] = DW'(k); arm_obs[k] = 1'b0;
      end
   endtask

   task automatic rand_stim(input int n);
      clear_stim();
      for (int k = 0; k < n; k++) begin
         v[k]  = ($urandom_range(0, 99) < 70);
         tr[k] = ($urandom_range(0, 99) < 15);
         ov[k] = ($urandom_range(0, 99) < 4);
         for (int j = 0; j < DW / 32; j++) d[k][j*32 +: 32] = $urandom;
      end
   endtask

   // Expected beats from the capture rules: find the trigger cycle, drop the
   // next `dly` valid beats, keep the next `len` valid beats, stop on overflow
   // or abort. Beat from input cycle k is expected at the output right after edge k.
   task automatic model(input logic [1:0] mode, input int dly, input int len, input int n);
      int a, t, skip, cnt;
      bit fin;
      exp_idx.delete(); exp_dat.delete();
      exp_done = 1'b0; exp_ovf = 1'b0; exp_cnt = '0; exp_busy = 1'b0;
      if (len == 0) begin
         exp_done = 1'b1;
         return;
      end
      a = n;
      for (int k = n - 1; k >= 1; k--) if (ab[k]) a = k;
      t = -1;
      if (mode == MODE_EDGE || mode == MODE_LEVEL) begin
         for (int k = 1; k < a; k++)
            if (t < 0 && tr[k] && (mode == MODE_LEVEL || !tr[k-1])) t = k;
      end else begin
         t = 0;
      end
      if (t < 0) begin
         exp_busy = (a == n);
         return;
      end
      skip = dly; cnt = 0; fin = 1'b0;
      for (int k = t + 1; k < a && !fin; k++) begin
         if (skip > 0) begin
            if (v[k]) skip--;
         end else begin
            if (v[k]) begin
               exp_idx.push_back(k);
               exp_dat.push_back(d[k]);
               cnt++;
            end
            if (cnt == len) fin = 1'b1;
            if (ov[k]) begin
               fin = 1'b1;
               exp_ovf = 1'b1;
            end
         end
      end
      exp_cnt  = LW'(cnt);
      exp_done = fin;
      exp_busy = !fin && (a == n);
   endtask

   task automatic run(input logic [1:0] mode, input logic [WW-1:0] dly, input logic [LW-1:0] len,
                      input logic [LW-1:0] len2, input int n, input string tag);
      int            oidx[$];
      logic [DW-1:0] odat[$];
      model(mode, int'(dly), int'(len), n);
      for (int k = 0; k < n; k++) begin
         cfg_start  = (k == 0) | st[k];
         cfg_abort  = ab[k];
         cfg_mode   = mode;
         cfg_delay  = dly;
         cfg_length = (k == 0) ? len : len2;
         trig_in    = tr[k];
         src.valid  = v[k];
         src.data   = d[k];
         adc_dovf   = ov[k];
         @(posedge adc_clk); #1;
         arm_obs[k] = status_armed;
         if (dst.valid) begin
            oidx.push_back(k);
            odat.push_back(dst.data);
         end
      end
      drive_idle();
      chk({tag, "_nbeats"}, DW'(oidx.size()), DW'(exp_idx.size()));
      for (int i = 0; i < oidx.size() && i < exp_idx.size(); i++) begin
         chk({tag, "_beat_cycle"}, DW'(oidx[i]), DW'(exp_idx[i]));
         chk({tag, "_beat_data"}, odat[i], exp_dat[i]);
      end
      chk({tag, "_done"},  DW'(status_done),  DW'(exp_done));
      chk({tag, "_ovf"},   DW'(status_ovf),   DW'(exp_ovf));
      chk({tag, "_count"}, DW'(status_count), DW'(exp_cnt));
      chk({tag, "_busy"},  DW'(status_busy),  DW'(exp_busy));
      // leave the sequencer idle for the next run without touching status
      cfg_abort = 1'b1;
      @(posedge adc_clk); #1;
      cfg_abort = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive_idle();
      adc_rst = 1'b1;
      repeat (2) @(posedge adc_clk);
      #1;
      chk("rst_valid", DW'(dst.valid),    '0);
      chk("rst_data",  dst.data,          '0);
      chk("rst_busy",  DW'(status_busy),  '0);
      chk("rst_armed", DW'(status_armed), '0);
      chk("rst_done",  DW'(status_done),  '0);
      chk("rst_ovf",   DW'(status_ovf),   '0);
      chk("rst_count", DW'(status_count), '0);
      adc_rst = 1'b0;
      @(posedge adc_clk); #1;

      // immediate, no delay, 4 beats of D1..D4
      clear_stim();
      for (int k = 0; k < MAXC; k++) v[k] = 1'b1;
      run(MODE_IMM, 16'd0, 16'd4, 16'd4, 8, "imm4");

      // edge mode with trigger high before start, later edge at cycle 10
      clear_stim();
      for (int k = 0; k < MAXC; k++) begin
         v[k]  = 1'b1;
         tr[k] = (k < 5) || (k >= 10);
      end
      run(MODE_EDGE, 16'd2, 16'd3, 16'd3, 20, "edge");
      chk("edge_armed_while_high", DW'(arm_obs[3]), DW'(1'b1));

      // overflow on the third captured beat
      clear_stim();
      for (int k = 0; k < MAXC; k++) v[k] = 1'b1;
      ov[3] = 1'b1;
      run(MODE_IMM, 16'd0, 16'd8, 16'd8, 12, "ovf");

      // abort while in DELAY, then a normal capture
      clear_stim();
      for (int k = 0; k < MAXC; k++) v[k] = k[0];
      ab[4] = 1'b1;
      run(MODE_IMM, 16'd5, 16'd3, 16'd3, 8, "abort");
      clear_stim();
      for (int k = 0; k < MAXC; k++) v[k] = 1'b1;
      run(MODE_IMM, 16'd1, 16'd2, 16'd2, 8, "after_abort");

      // start while capturing is ignored (a different length is offered)
      clear_stim();
      for (int k = 0; k < MAXC; k++) v[k] = 1'b1;
      st[3] = 1'b1;
      run(MODE_IMM, 16'd0, 16'd5, 16'd2, 10, "restart_ign");

      // zero length completes immediately
      clear_stim();
      for (int k = 0; k < MAXC; k++) v[k] = 1'b1;
      run(MODE_IMM, 16'd0, 16'd0, 16'd0, 4, "len0");

      // gapped valid in capture
      clear_stim();
      v[1] = 1'b1; v[3] = 1'b1;
      run(MODE_IMM, 16'd0, 16'd2, 16'd2, 8, "toggle");

      // reset in the middle of a capture
      cfg_mode = MODE_IMM; cfg_delay = '0; cfg_length = 16'd10; cfg_start = 1'b1;
      src.valid = 1'b1; src.data = DW'(32'hA5);
      @(posedge adc_clk); #1;
      cfg_start = 1'b0;
      repeat (2) @(posedge adc_clk);
      #1;
      chk("midrst_pre_valid", DW'(dst.valid), DW'(1'b1));
      adc_rst = 1'b1;
      @(posedge adc_clk); #1;
      chk("midrst_valid", DW'(dst.valid),    '0);
      chk("midrst_busy",  DW'(status_busy),  '0);
      chk("midrst_count", DW'(status_count), '0);
      adc_rst = 1'b0;
      drive_idle();
      @(posedge adc_clk); #1;

      // randomized runs over all modes
      for (int r = 0; r < 16; r++) begin
         logic [1:0]    m;
         logic [WW-1:0] dl;
         logic [LW-1:0] ln;
         m  = 2'($urandom_range(0, 3));
         dl = WW'($urandom_range(0, 3));
         ln = LW'($urandom_range(1, 6));
         rand_stim(40);
         run(m, dl, ln, ln, 40, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad_adc_capture_seq.md
# ad_adc_capture_seq

Capture sequencer between the AD9625 interface/channel datapath and the DMA write port, all in the `adc_clk` domain. It arms on a software start, waits for a trigger (immediate, edge or level), skips a programmable number of beats, then forwards exactly `cfg_length` valid beats of `DATA_WIDTH` samples to the DMA and stops. DMA overflow (`adc_dovf`) aborts the capture and is reported as status.

## Interface
Parameters:
- `DATA_WIDTH`, 256, sample beat width (16 × 16-bit samples)
- `LENGTH_WIDTH`, 16, width of the beat-length counter
- `DELAY_WIDTH`, 16, width of the post-trigger delay counter

Ports:
- `adc_clk`  in  1  clock; the only clock
- `adc_rst`  in  1  synchronous, active-high reset
- `cfg_start`  in  1  one-cycle start pulse; latches `cfg_*`
- `cfg_abort`  in  1  one-cycle abort pulse
- `cfg_mode`  in  2  0 immediate, 1 trigger rising edge, 2 trigger high level, 3 treated as 0
- `cfg_delay`  in  DELAY_WIDTH  valid beats skipped after trigger
- `cfg_length`  in  LENGTH_WIDTH  beats to capture
- `trig_in`  in  1  external trigger, already in the `adc_clk` domain
- `adc_valid_in`  in  1  beat valid from the channel
- `adc_data_in`  in  DATA_WIDTH  beat data from the channel
- `adc_dovf`  in  1  DMA overflow
- `adc_valid`  out  1  beat valid to the DMA
- `adc_data`  out  DATA_WIDTH  beat data to the DMA
- `status_busy`  out  1  asserted in ARMED, DELAY or CAPTURE
- `status_armed`  out  1  asserted in ARMED
- `status_done`  out  1  sticky; set on completion, cleared by the next accepted start
- `status_ovf`  out  1  sticky; set on an overflow abort, cleared by the next accepted start
- `status_count`  out  LENGTH_WIDTH  beats captured in the current or last run

## Operation
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
- Start is accepted only in IDLE or DONE. Starts in any other state are ignored.
- On an accepted start: latch mode, delay and length; clear `status_done`, `status_ovf` and `status_count`; clear the delay counter.
- Next state after an accepted start:
  - length 0: go to DONE with `status_done` set.
  - mode 0/3 with delay 0: go to CAPTURE.
  - mode 0/3 with delay ≠ 0: go to DELAY.
  - mode 1/2: go to ARMED.
- Trigger detection:
  - Rising edge is `trig_in & ~trig_d`. `trig_d` is registered every cycle and reset to 0.
  - A trigger that is already high at arm time does not fire mode 1.
  - Level mode fires on any cycle `trig_in` = 1 while in ARMED.
- ARMED → DELAY (delay ≠ 0) or CAPTURE (delay = 0) on the trigger cycle. The trigger-cycle beat is never forwarded.
- DELAY: each `adc_valid_in` beat increments the delay counter. The beat that makes the count equal the latched delay moves the FSM to CAPTURE and is not forwarded.
- CAPTURE: each `adc_valid_in` beat is forwarded and `status_count` increments. The beat that makes the count equal the length moves the FSM to DONE and sets `status_done`.
- Overflow: `adc_dovf` = 1 in CAPTURE sets `status_ovf` and moves the FSM to DONE with `status_done` set.
  - A beat arriving on the same cycle is still forwarded and counted.
  - `adc_dovf` is ignored outside CAPTURE.
- Abort: `cfg_abort` in any state moves the FSM to IDLE. Status flags and count are kept, `status_done` is not set, and no beat is forwarded on the abort cycle.
- Abort and start in the same cycle: abort wins.
- Counter width: length up to 2^LENGTH_WIDTH−1. No wrap is possible because the FSM leaves CAPTURE at the length.

## Timing
- Reset values: state IDLE, `adc_valid` 0, `adc_data` 0, all status outputs 0, `trig_d` 0.
- Datapath latency: exactly 1 cycle. `adc_valid`/`adc_data` are registered from `adc_valid_in`/`adc_data_in` of the previous cycle, gated by CAPTURE.
- `adc_data` holds its last value when `adc_valid` = 0.
- The state changes on the clock edge after the qualifying input.
- `status_*` outputs are registered and update on the same edge as the state.
- A start-to-CAPTURE transition (mode 0, delay 0) forwards a beat that is valid in the cycle after the start.
- No backpressure: the DMA always accepts beats.
- Reset mid-capture: the next cycle is in reset state and `adc_valid` is 0.

## Structure
- Package `ad_adc_capture_pkg`: state enum encoding and mode constants (`MODE_IMM`, `MODE_EDGE`, `MODE_LEVEL`).
- One natural sub-module, `ad_trig_detect`: holds the `trig_d` register and produces `fire` from mode and `trig_in`.
- All other logic stays in the top FSM.

## Test plan
- Mode 0, delay 0, length 4, `adc_valid_in` = 1 continuously with incrementing data starting at D1 in the cycle after start → `adc_valid` high for 4 cycles carrying D1..D4, then `status_done` = 1 and `status_count` = 4.
- Mode 1, `trig_in` held high before start → stays ARMED. Drop `trig_in`, raise it at cycle T → delay 2 skips 2 valid beats after T, length 3 forwards the next 3.
- Mode 0, length 8, `adc_dovf` pulsed on the 3rd captured beat → 3 beats forwarded, `status_ovf` = 1, `status_done` = 1, `status_count` = 3.
- `cfg_abort` asserted during DELAY → IDLE, no beats forwarded, `status_done` = 0. A new start then completes normally.
- Start while CAPTURE is running → ignored, and the original length completes. Start with length 0 → DONE next cycle with count 0 and no valid beats.
- `adc_valid_in` toggling 1,0,1,0 in CAPTURE with length 2 → exactly 2 output beats, each 1 cycle after its input beat.
